data_memory: RTL and testbench
==============================

# data_memory

Byte-addressable data memory for the single-cycle RV32I datapath. It executes the load/store commands the control unit issues on `DMWr`/`DMCtrl`, with the ALU result as the address and the second register-file read port as store data. Stores are clocked. Loads are combinational, so `DataRd` reaches the `RUDataWrSrc = 01` write-back mux in the same cycle. Stores perform byte/half/word lane merging; loads perform sign or zero extension.

## Interface

Parameters:
- `DEPTH_BYTES`, 1024: memory size in bytes; power of two, ≥ 4.
- `ADDR_BITS`, $clog2(DEPTH_BYTES): number of low address bits used to index the array.

Ports:
- `clk`  in  1  system clock; all stores occur on the rising edge.
- `rst`  in  1  asynchronous, active-high reset; clears the whole array.
- `Address`  in  32  byte address (ALU result); only `Address[ADDR_BITS-1:0]` is used.
- `DataWr`  in  32  store data (rs2); low byte / low half / full word is used depending on access size.
- `DMWr`  in  1  store enable from the control unit.
- `DMCtrl`  in  3  access control from the control unit: `[1:0]` is size, `[2]` is unsigned-load.
- `DataRd`  out  32  load result after extension; combinational.

## Operation

- Storage is an array of `DEPTH_BYTES` bytes, little-endian.
  - Byte k of an access is located at `(Address + k) mod DEPTH_BYTES`.
- Access size from `DMCtrl[1:0]`:
  - `00` is byte (1 byte).
  - `01` is half (2 bytes).
  - `10` and `11` are word (4 bytes).
- Load extension from `DMCtrl[2]`:
  - 0: sign-extend from the top bit of the accessed size.
  - 1: zero-extend.
  - Word loads ignore `DMCtrl[2]`.
- Decoded load encodings:
  - `000` LB
  - `001` LH
  - `010` LW
  - `100` LBU
  - `101` LHU
  - `011`, `110` and `111` behave as LW.
- Store encodings:
  - `000` SB writes `DataWr[7:0]`.
  - `001` SH writes `DataWr[15:0]`.
  - `010` SW writes `DataWr[31:0]`.
  - Stores ignore `DMCtrl[2]`; for example, `100` stores a byte.
- Store behaviour:
  - Only the addressed bytes change; all other bytes keep their contents.
  - `DataWr` bits above the access size are ignored.
- `DataRd` is driven continuously from the current array contents, `Address` and `DMCtrl`, independent of `DMWr`.
  - For a store cycle the datapath discards it; it must still be well-defined.
- Misaligned accesses are legal and execute bytewise. No trap is raised and no alignment flag is produced.
- Address bits at and above `ADDR_BITS` are ignored. Addresses alias modulo `DEPTH_BYTES`.
- Wrap-around: a half or word access starting within the last 1–3 bytes continues at byte 0.

## Timing

- Reset:
  - While `rst = 1`, every array byte is 0 immediately (asynchronously), so `DataRd = 32'h0`.
  - Stores are blocked while `rst = 1`.
  - After deassertion, the array stays all-zero until the first store.
- Store latency:
  - The array updates on the rising `clk` edge where `DMWr = 1` and `rst = 0`.
  - `Address`, `DataWr` and `DMCtrl` are sampled at that edge.
- Load latency: zero cycles. `DataRd` follows `Address`/`DMCtrl` changes combinationally within the same cycle.
- Read-during-write to overlapping bytes:
  - Before the edge, `DataRd` shows the old contents.
  - After the edge, it shows the new contents.
  - There is no bypass.
- `rst` asserted coincident with a store edge: reset wins and the array is all-zero.
- `rst` asserted mid-cycle after a store edge: the stored data is lost and the array clears.
- `DMWr = 1` with `X`/`Z` on `DataWr` writes `X` bytes. The bench treats this as illegal stimulus.

## Test plan

- Reset state:
  - Stimulus: assert `rst` with `DMWr = 1`, `Address = 0x10`, `DataWr = 0xFFFFFFFF`, clock twice.
  - Required: `DataRd = 0x00000000` throughout; after release, LW at `0x10` returns `0x00000000`.
- Word store and load:
  - Stimulus: SW `0xDEADBEEF` to `0x20`, then LW at `0x20`.
  - Required: LW returns `0xDEADBEEF`.
  - Stimulus: LB `0x20`, LBU `0x20`, LH `0x22`, LHU `0x22`.
  - Required, in order: `0xFFFFFFEF`, `0x000000EF`, `0xFFFFDEAD`, `0x0000DEAD`.
- Partial store merge:
  - Stimulus: after the word test, SB `0x12345677` to `0x21`, then SH `0xAAAA8001` to `0x22`.
  - Required: LW at `0x20` returns `0x800177EF`.
- Misaligned and wrap access (`DEPTH_BYTES = 1024`):
  - Stimulus: SW `0x11223344` to `0x3FE`.
  - Required: LW at `0x3FE` returns `0x11223344`; LH at `0x000` returns `0x00001122`; LW at `0x400` aliases to `0x000`.
- Store disabled and read-during-write:
  - Stimulus: `DMWr = 0` with `DataWr = 0x55555555` at `0x20`.
  - Required: contents unchanged.
  - Stimulus: SW `0xCAFEF00D` to `0x20` with LW on the same address.
  - Required: `DataRd` shows the old word before the edge and `0xCAFEF00D` after it.
- Reset mid-operation:
  - Stimulus: SW `0x0BADF00D` to `0x40`, then pulse `rst` for 3 ns mid-cycle without a clock edge.
  - Required: LW at `0x40` returns `0x00000000` during and after the pulse.

Source files
------------

// File: rtl/data_memory.sv
// data_memory: byte-addressable little-endian data memory with clocked stores and combinational loads.
// Stores merge byte/half/word lanes; loads sign- or zero-extend; accesses wrap modulo DEPTH_BYTES.
module data_memory #(
   parameter int DEPTH_BYTES = 1024,
   parameter int ADDR_BITS   = $clog2(DEPTH_BYTES)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Address,
   input  logic [31:0] DataWr,
   input  logic        DMWr,
   input  logic [2:0]  DMCtrl,
   output logic [31:0] DataRd
);
   logic [7:0]           r_mem [DEPTH_BYTES];
   logic [ADDR_BITS-1:0] w_a0, w_a1, w_a2, w_a3;
   logic                 w_word, w_half, w_sext_b, w_sext_h;
   logic [7:0]           w_b0, w_b1, w_b2, w_b3;
   logic                 w_unused;
   // Lane addresses wrap naturally in ADDR_BITS-wide arithmetic.
   assign w_a0     = Address[ADDR_BITS-1:0];
   assign w_a1     = w_a0 + ADDR_BITS'(1);
   assign w_a2     = w_a0 + ADDR_BITS'(2);
   assign w_a3     = w_a0 + ADDR_BITS'(3);
   assign w_unused = ^Address[31:ADDR_BITS];
   assign w_word   = DMCtrl[1];
   assign w_half   = DMCtrl[1:0] == 2'b01;
   assign w_b0     = r_mem[w_a0];
   assign w_b1     = r_mem[w_a1];
   assign w_b2     = r_mem[w_a2];
   assign w_b3     = r_mem[w_a3];
   assign w_sext_b = ~DMCtrl[2] & w_b0[7];
   assign w_sext_h = ~DMCtrl[2] & w_b1[7];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH_BYTES; i++) r_mem[i] <= 8'h00;
      end else if (DMWr) begin
         r_mem[w_a0] <= DataWr[7:0];
         if (w_half || w_word) r_mem[w_a1] <= DataWr[15:8];
         if (w_word) begin
            r_mem[w_a2] <= DataWr[23:16];
            r_mem[w_a3] <= DataWr[31:24];
         end
      end
   end
   always_comb begin
      DataRd = w_word ? {w_b3, w_b2, w_b1, w_b0} :
               w_half ? {{16{w_sext_h}}, w_b1, w_b0} :
                        {{24{w_sext_b}}, w_b0};
   end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed self-checking bench for data_memory stores, loads, wrap and reset.
module tb_data_memory;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] Address = 32'h0;
   logic [31:0] DataWr = 32'h0;
   logic        DMWr = 1'b0;
   logic [2:0]  DMCtrl = 3'b010;
   logic [31:0] DataRd;
   int          checks = 0;
   int          errors = 0;

   data_memory #(.DEPTH_BYTES(1024)) dut (
      .clk(clk), .rst(rst), .Address(Address), .DataWr(DataWr),
      .DMWr(DMWr), .DMCtrl(DMCtrl), .DataRd(DataRd)
   );

   always #5 clk = ~clk;

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
      @(negedge clk);
      Address = a; DataWr = d; DMCtrl = c; DMWr = 1'b1;
      @(posedge clk);
      #1 DMWr = 1'b0;
   endtask

   task automatic set_rd(input logic [31:0] a, input logic [2:0] c);
      Address = a; DMCtrl = c;
      #1;
   endtask

   task automatic test_reset;
      #2 rst = 1'b1;
      DMWr = 1'b1; Address = 32'h10; DataWr = 32'hFFFF_FFFF; DMCtrl = 3'b010;
      #1 checks++;
      if (DataRd !== 32'h0) begin errors++; $display("FAIL reset_async got %h exp %h", DataRd, 32'h0); end
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1 checks++;
         if (DataRd !== 32'h0) begin errors++; $display("FAIL reset_edge%0d got %h exp %h", k, DataRd, 32'h0); end
      end
      @(negedge clk);
      DMWr = 1'b0; rst = 1'b0;
      set_rd(32'h10, 3'b010);
      checks++;
      if (DataRd !== 32'h0) begin errors++; $display("FAIL reset_after got %h exp %h", DataRd, 32'h0); end
   endtask

   task automatic test_word;
      logic [2:0]  ctl [6] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b110};
      logic [31:0] adr [6] = '{32'h20, 32'h20, 32'h20, 32'h22, 32'h22, 32'h20};
      logic [31:0] exp [6] = '{32'hDEADBEEF, 32'hFFFFFFEF, 32'h000000EF,
                               32'hFFFFDEAD, 32'h0000DEAD, 32'hDEADBEEF};
      do_store(32'h20, 32'hDEAD_BEEF, 3'b010);
      for (int i = 0; i < 6; i++) begin
         set_rd(adr[i], ctl[i]);
         checks++;
         if (DataRd !== exp[i]) begin errors++; $display("FAIL word_load%0d got %h exp %h", i, DataRd, exp[i]); end
      end
   endtask

   task automatic test_merge;
      do_store(32'h21, 32'h1234_5677, 3'b000);
      do_store(32'h22, 32'hAAAA_8001, 3'b001);
      set_rd(32'h20, 3'b010);
      checks++;
      if (DataRd !== 32'h800177EF) begin errors++; $display("FAIL merge got %h exp %h", DataRd, 32'h800177EF); end
      do_store(32'h60, 32'hFFFF_FF9C, 3'b100);
      set_rd(32'h60, 3'b011);
      checks++;
      if (DataRd !== 32'h0000009C) begin errors++; $display("FAIL store_ctrl100 got %h exp %h", DataRd, 32'h0000009C); end
   endtask

   task automatic test_wrap;
      do_store(32'h3FE, 32'h1122_3344, 3'b010);
      set_rd(32'h3FE, 3'b010);
      checks++;
      if (DataRd !== 32'h11223344) begin errors++; $display("FAIL wrap_lw got %h exp %h", DataRd, 32'h11223344); end
      set_rd(32'h000, 3'b001);
      checks++;
      if (DataRd !== 32'h00001122) begin errors++; $display("FAIL wrap_lh0 got %h exp %h", DataRd, 32'h00001122); end
      set_rd(32'h400, 3'b010);
      checks++;
      if (DataRd !== 32'h00001122) begin errors++; $display("FAIL alias_400 got %h exp %h", DataRd, 32'h00001122); end
      set_rd(32'hFFFF_F3FF, 3'b000);
      checks++;
      if (DataRd !== 32'h00000033) begin errors++; $display("FAIL alias_high got %h exp %h", DataRd, 32'h00000033); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      Address = 32'h20; DataWr = 32'h5555_5555; DMCtrl = 3'b010; DMWr = 1'b0;
      @(posedge clk); #1 checks++;
      if (DataRd !== 32'h800177EF) begin errors++; $display("FAIL no_write got %h exp %h", DataRd, 32'h800177EF); end
      @(negedge clk);
      DataWr = 32'hCAFE_F00D; DMWr = 1'b1;
      #1 checks++;
      if (DataRd !== 32'h800177EF) begin errors++; $display("FAIL rdw_before got %h exp %h", DataRd, 32'h800177EF); end
      @(posedge clk); #1 checks++;
      if (DataRd !== 32'hCAFEF00D) begin errors++; $display("FAIL rdw_after got %h exp %h", DataRd, 32'hCAFEF00D); end
      DMWr = 1'b0;
   endtask

   task automatic test_reset_mid;
      do_store(32'h40, 32'h0BAD_F00D, 3'b010);
      set_rd(32'h40, 3'b010);
      checks++;
      if (DataRd !== 32'h0BADF00D) begin errors++; $display("FAIL mid_pre got %h exp %h", DataRd, 32'h0BADF00D); end
      rst = 1'b1;
      #1 checks++;
      if (DataRd !== 32'h0) begin errors++; $display("FAIL mid_during got %h exp %h", DataRd, 32'h0); end
      #2 rst = 1'b0;
      #1 checks++;
      if (DataRd !== 32'h0) begin errors++; $display("FAIL mid_after got %h exp %h", DataRd, 32'h0); end
      set_rd(32'h20, 3'b010);
      checks++;
      if (DataRd !== 32'h0) begin errors++; $display("FAIL mid_other got %h exp %h", DataRd, 32'h0); end
   endtask

   initial begin
      test_reset;
      test_word;
      test_merge;
      test_wrap;
      test_back_to_back;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
